// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite pattern RAM loader.
package ghost_pkg;

  localparam int PIX_W        = 2;
  localparam int PIX_PER_WORD = 16;
  localparam int WORD_ADDR_W  = 6;
  localparam int WORD_BITS    = PIX_W * PIX_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    CLEAR
  } loader_state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [WORD_BITS-1:0]   data;
  } fifo_entry_t;

endpackage

// File: rtl/ghost_word_fifo.sv
// Two-entry synchronous FIFO holding packed pattern words ahead of the unpacker.
module ghost_word_fifo
  import ghost_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_push,
  input  fifo_entry_t i_din,
  input  logic        i_pop,
  output fifo_entry_t o_dout,
  output logic [1:0]  o_count,
  output logic        o_full,
  output logic        o_empty
);

  fifo_entry_t r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ghost_ram_loader.sv
// Serialises packed 16-pixel pattern words into single-pixel sprite RAM writes
// and performs a full-RAM chroma-key clear on request.
module ghost_ram_loader
  import ghost_pkg::*;
#(
  parameter int ADDR       = 10,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR-5:0]   wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              we,
  output logic [ADDR-1:0]   addr_w,
  output logic [PIX_W-1:0]  pixel_in,
  output logic              busy,
  output logic              clr_done
);

  loader_state_e r_state;
  loader_state_e w_next;
  fifo_entry_t   r_word;
  fifo_entry_t   w_fifo_dout;
  fifo_entry_t   w_in_entry;
  logic [3:0]    r_col;
  logic [ADDR-1:0] r_clr_addr;
  logic          r_clr_pend;
  logic          r_clr_done;
  logic [1:0]    w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_last;
  logic          w_need;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic          w_load;
  logic          w_clr_last;

  assign w_in_entry = fifo_entry_t'({wr_addr, wr_data});
  assign wr_ready   = (int'(w_count) < FIFO_DEPTH) && !r_clr_pend && (r_state != CLEAR);
  assign w_accept   = wr_valid && wr_ready;
  assign w_last     = (r_state == UNPACK) && (r_col == 4'(PIX_PER_WORD - 1));
  assign w_need     = (r_state == IDLE) || w_last;
  // An accepted word skips the FIFO when the unpacker wants one and nothing is queued.
  assign w_pop      = w_need && !w_empty;
  assign w_bypass   = w_need && w_empty && w_accept;
  assign w_push     = w_accept && !w_bypass && !w_full;
  assign w_load     = w_pop || w_bypass;
  assign w_clr_last = (r_state == CLEAR) && (&r_clr_addr);
  assign busy       = (r_state != IDLE) || !w_empty || r_clr_pend;
  assign clr_done   = r_clr_done;

  ghost_word_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_in_entry),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Queued words always drain before a pending clear is allowed to start.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_load)          w_next = UNPACK;
        else if (r_clr_pend) w_next = CLEAR;
      end
      UNPACK: begin
        if (w_last) begin
          if (w_load)          w_next = UNPACK;
          else if (r_clr_pend) w_next = CLEAR;
          else                 w_next = IDLE;
        end
      end
      CLEAR: begin
        if (w_clr_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    we       = 1'b0;
    addr_w   = '0;
    pixel_in = '0;
    case (r_state)
      UNPACK: begin
        we       = 1'b1;
        addr_w   = {r_word.addr, r_col};
        pixel_in = r_word.data[{r_col, 1'b0} +: PIX_W];
      end
      CLEAR: begin
        we     = 1'b1;
        addr_w = r_clr_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word     <= '0;
      r_col      <= 4'd0;
      r_clr_addr <= '0;
      r_clr_pend <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_word <= w_pop ? w_fifo_dout : w_in_entry;
        r_col  <= 4'd0;
      end else if ((r_state == UNPACK) && !w_last) begin
        r_col <= r_col + 4'd1;
      end

      if ((w_next == CLEAR) && (r_state != CLEAR)) r_clr_addr <= '0;
      else if (r_state == CLEAR)                   r_clr_addr <= r_clr_addr + 1'b1;

      r_clr_done <= w_clr_last;

      if (w_clr_last)   r_clr_pend <= 1'b0;
      else if (clr_req) r_clr_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ghost_ram_loader.sv
// Directed self-checking bench for ghost_ram_loader: single word, back-to-back,
// clear, clear ordering against queued words, and reset abort.
module tb_ghost_ram_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clr_req = 1'b0;
  logic        we;
  logic [9:0]  addr_w;
  logic [1:0]  pixel_in;
  logic        busy;
  logic        clr_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ghost_ram_loader #(.ADDR(10), .WORD_W(32), .FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .we       (we),
    .addr_w   (addr_w),
    .pixel_in (pixel_in),
    .busy     (busy),
    .clr_done (clr_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    total++;
    if ({we, addr_w, pixel_in, busy, clr_done} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got %b want all zero", {we, addr_w, pixel_in, busy, clr_done});
    end
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready got %b want 1", wr_ready);
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    total++;
    if ({we, busy, wr_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL post_reset got we/busy/ready=%b want 001", {we, busy, wr_ready});
    end
  endtask

  task automatic test_single_word();
    logic [9:0] expAddr;
    logic [1:0] expPix;
    wr_valid = 1'b1;
    wr_addr  = 6'h12;
    wr_data  = 32'hE4E4_E4E4;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_ready got %b want 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      expAddr = 10'h120 + 10'(c);
      expPix  = 2'(c % 4);
      total++;
      if ({we, addr_w, pixel_in} !== {1'b1, expAddr, expPix}) begin
        bad++;
        $display("[TB] FAIL single_word c=%0d got we=%b addr=%h pix=%0d want we=1 addr=%h pix=%0d",
                 c, we, addr_w, pixel_in, expAddr, expPix);
      end
      step();
    end
    total++;
    if ({we, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL single_end got we/busy=%b want 00", {we, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ba [3] = '{6'h05, 6'h2A, 6'h3F};
    logic [31:0] bd [3] = '{32'h1B1B_1B1B, 32'hFFFF_0000, 32'h0123_4567};
    logic [31:0] d;
    logic [9:0]  expAddr;
    logic [1:0]  expPix;
    int idx = 0;
    int writes = 0;
    int gaps = 0;
    logic accepted;
    wr_valid = 1'b1;
    wr_addr  = ba[0];
    wr_data  = bd[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      accepted = wr_valid && wr_ready;
      step();
      if (accepted) begin
        idx++;
        if (idx == 3) begin
          wr_valid = 1'b0;
          total++;
          if (wr_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_full_ready got %b want 0", wr_ready);
          end
        end else begin
          wr_addr = ba[idx];
          wr_data = bd[idx];
        end
      end
      if (we === 1'b1) begin
        if (writes < 48) begin
          d       = bd[writes / 16];
          expAddr = {ba[writes / 16], 4'(writes % 16)};
          expPix  = d[2 * (writes % 16) +: 2];
          total++;
          if ({addr_w, pixel_in} !== {expAddr, expPix}) begin
            bad++;
            $display("[TB] FAIL b2b_write n=%0d got addr=%h pix=%0d want addr=%h pix=%0d",
                     writes, addr_w, pixel_in, expAddr, expPix);
          end
        end
        writes++;
      end else if (writes > 0 && writes < 48) begin
        gaps++;
      end
    end
    total++;
    if (writes !== 48) begin
      bad++;
      $display("[TB] FAIL b2b_count got %0d want 48", writes);
    end
    total++;
    if (gaps !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_gaps got %0d want 0", gaps);
    end
    total++;
    if ({busy, wr_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL b2b_idle got busy/ready=%b want 01", {busy, wr_ready});
    end
  endtask

  task automatic test_clear();
    logic seen = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    total++;
    if ({wr_ready, busy} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL clear_pending got ready/busy=%b want 01", {wr_ready, busy});
    end
    for (int i = 0; i < 4 && !seen; i++) begin
      if (we === 1'b1) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL clear_start got we=%b want 1", we);
    end else begin
      for (int a = 0; a < 1024; a++) begin
        total++;
        if ({we, addr_w, pixel_in, wr_ready, clr_done} !== {1'b1, 10'(a), 2'b00, 1'b0, 1'b0}) begin
          bad++;
          $display("[TB] FAIL clear_write a=%0d got we=%b addr=%h pix=%0d ready=%b done=%b want 1/%h/0/0/0",
                   a, we, addr_w, pixel_in, wr_ready, clr_done, 10'(a));
        end
        step();
      end
      total++;
      if ({clr_done, we} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL clear_done got done/we=%b want 10", {clr_done, we});
      end
      step();
      total++;
      if ({clr_done, wr_ready, busy} !== 3'b010) begin
        bad++;
        $display("[TB] FAIL clear_after got done/ready/busy=%b want 010", {clr_done, wr_ready, busy});
      end
    end
  endtask

  task automatic test_clear_during_unpack();
    logic [31:0] wd [2] = '{32'hA5A5_5A5A, 32'h3C3C_C3C3};
    logic [31:0] d;
    logic [9:0]  expAddr;
    logic [1:0]  expPix;
    int writes = 0;
    int doneCnt = 0;
    logic second = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 6'h00;
    wr_data  = wd[0];
    for (int cyc = 0; cyc < 1100; cyc++) begin
      step();
      if (clr_done === 1'b1) doneCnt++;
      if (we === 1'b1) begin
        if (writes < 32) begin
          d       = wd[writes / 16];
          expAddr = {6'(writes / 16), 4'(writes % 16)};
          expPix  = d[2 * (writes % 16) +: 2];
        end else begin
          expAddr = 10'(writes - 32);
          expPix  = 2'b00;
        end
        total++;
        if ({addr_w, pixel_in} !== {expAddr, expPix}) begin
          bad++;
          $display("[TB] FAIL cdu_write n=%0d got addr=%h pix=%0d want addr=%h pix=%0d",
                   writes, addr_w, pixel_in, expAddr, expPix);
        end
        writes++;
      end
      wr_valid = 1'b0;
      clr_req  = 1'b0;
      if (cyc == 0) begin
        wr_valid = 1'b1;
        wr_addr  = 6'h01;
        wr_data  = wd[1];
      end
      if (cyc == 5) begin
        clr_req = 1'b1;
        total++;
        if (addr_w !== 10'h005) begin
          bad++;
          $display("[TB] FAIL cdu_col5 got addr=%h want 005", addr_w);
        end
      end
      if (writes == 132 && !second) begin
        clr_req = 1'b1;
        second  = 1'b1;
      end
    end
    total++;
    if (writes !== 1056) begin
      bad++;
      $display("[TB] FAIL cdu_count got %0d want 1056", writes);
    end
    total++;
    if (doneCnt !== 1) begin
      bad++;
      $display("[TB] FAIL cdu_done_pulses got %0d want 1", doneCnt);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cdu_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d = 32'h9C63_A5F0;
    logic [9:0]  expAddr;
    logic [1:0]  expPix;
    int writes = 0;
    int doneCnt = 0;
    wr_valid = 1'b1;
    wr_addr  = 6'h2C;
    wr_data  = d;
    clr_req  = 1'b1;
    for (int cyc = 0; cyc < 1080; cyc++) begin
      step();
      wr_valid = 1'b0;
      clr_req  = 1'b0;
      if (clr_done === 1'b1) doneCnt++;
      if (we === 1'b1) begin
        if (writes < 16) begin
          expAddr = {6'h2C, 4'(writes)};
          expPix  = d[2 * writes +: 2];
        end else begin
          expAddr = 10'(writes - 16);
          expPix  = 2'b00;
        end
        total++;
        if ({addr_w, pixel_in} !== {expAddr, expPix}) begin
          bad++;
          $display("[TB] FAIL simul_write n=%0d got addr=%h pix=%0d want addr=%h pix=%0d",
                   writes, addr_w, pixel_in, expAddr, expPix);
        end
        writes++;
      end
    end
    total++;
    if (writes !== 1040) begin
      bad++;
      $display("[TB] FAIL simul_count got %0d want 1040", writes);
    end
    total++;
    if (doneCnt !== 1) begin
      bad++;
      $display("[TB] FAIL simul_done_pulses got %0d want 1", doneCnt);
    end
  endtask

  task automatic test_reset_mid_word();
    int strayWrites = 0;
    wr_valid = 1'b1;
    wr_addr  = 6'h0F;
    wr_data  = 32'hFFFF_FFFF;
    step();
    wr_addr  = 6'h10;
    wr_data  = 32'h5555_5555;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    total++;
    if ({we, addr_w} !== {1'b1, 10'h0F8}) begin
      bad++;
      $display("[TB] FAIL rst_col8 got we=%b addr=%h want we=1 addr=0f8", we, addr_w);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({we, busy, addr_w, pixel_in} !== 14'd0) begin
      bad++;
      $display("[TB] FAIL rst_abort got we=%b busy=%b addr=%h pix=%0d want all zero", we, busy, addr_w, pixel_in);
    end
    step();
    reset_n = 1'b1;
    total++;
    if ({wr_ready, busy} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL rst_release got ready/busy=%b want 10", {wr_ready, busy});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (we !== 1'b0) strayWrites++;
    end
    total++;
    if (strayWrites !== 0) begin
      bad++;
      $display("[TB] FAIL rst_no_writes got %0d writes want 0", strayWrites);
    end
    total++;
    if ({busy, wr_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL rst_final got busy/ready=%b want 01", {busy, wr_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    step();
    test_back_to_back();
    step();
    test_clear();
    step();
    test_clear_during_unpack();
    step();
    test_simultaneous();
    step();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
